// File: rtl/spe_accumulator.sv
// Summation PE: folds NUM_PARTIALS partial sums into one neuron contribution,
// integrates it into that neuron's membrane potential, thresholds it and
// emits one spike packet per neuron. Opcode 15 closes a timestep.
module spe_accumulator #(
    parameter int SPE_ID        = 0,
    parameter int OMEM_ID       = 11,
    parameter int NUM_PARTIALS  = 5,
    parameter int NUM_NEURONS   = 89,
    parameter int NUM_TIMESTEPS = 2,
    parameter int PSUM_WIDTH    = 14,
    parameter int VMEM_WIDTH    = 16,
    parameter int THRESHOLD     = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [32:0] i_in_packet,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [32:0] o_out_packet,
    output logic        o_err
);

    localparam int ACC_W  = PSUM_WIDTH + 3;
    localparam int SUM_W  = ((ACC_W > VMEM_WIDTH) ? ACC_W : VMEM_WIDTH) + 1;
    localparam int NIDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int TS_W   = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1;
    localparam int PCNT_W = $clog2(NUM_PARTIALS + 1);

    localparam logic signed [SUM_W-1:0] VMAX =
        {{(SUM_W-VMEM_WIDTH+1){1'b0}}, {(VMEM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] VMIN =
        {{(SUM_W-VMEM_WIDTH+1){1'b1}}, {(VMEM_WIDTH-1){1'b0}}};
    localparam logic signed [VMEM_WIDTH-1:0] THR = VMEM_WIDTH'(THRESHOLD);

    localparam logic [3:0] OP_PSUM = 4'd0;
    localparam logic [3:0] OP_DONE = 4'd15;

    typedef enum logic [1:0] {ACCUM, FIRE, SEND} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic                          r_rdy;        // low only in the cycle(s) following a reset edge
    logic signed [ACC_W-1:0]       r_group_acc;
    logic [PCNT_W-1:0]             r_part_cnt;
    logic [NIDX_W-1:0]             r_nidx;
    logic [TS_W-1:0]               r_ts;
    logic signed [VMEM_WIDTH-1:0]  r_vmem [NUM_NEURONS];
    logic [32:0]                   r_out_packet;
    logic                          r_err;

    logic                          w_accept;
    logic [3:0]                    w_op;
    logic signed [PSUM_WIDTH-1:0]  w_psum;
    logic signed [ACC_W-1:0]       w_psum_ext;
    logic                          w_last_part;
    logic signed [SUM_W-1:0]       w_sum;
    logic signed [VMEM_WIDTH-1:0]  w_v;
    logic                          w_spike;
    logic [24:0]                   w_fire_data;
    logic [24:0]                   w_done_data;
    logic                          w_unused;

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_op        = i_in_packet[28:25];
    assign w_psum      = i_in_packet[PSUM_WIDTH-1:0];
    assign w_psum_ext  = ACC_W'(w_psum);
    assign w_last_part = (r_part_cnt == PCNT_W'(NUM_PARTIALS - 1));
    assign w_sum       = SUM_W'(r_vmem[r_nidx]) + SUM_W'(r_group_acc);
    assign w_spike     = (w_v >= THR);
    // Address bits and the upper data bits carry nothing for this block.
    assign w_unused    = ^{i_in_packet[32:29], i_in_packet[24:PSUM_WIDTH]};

    // Clamp the widened sum back into the membrane-potential range.
    always_comb begin
        w_v = w_sum[VMEM_WIDTH-1:0];
        if (w_sum > VMAX)
            w_v = VMAX[VMEM_WIDTH-1:0];
        else if (w_sum < VMIN)
            w_v = VMIN[VMEM_WIDTH-1:0];
    end

    // Payloads for the spike packet and the timestep-done packet.
    always_comb begin
        w_fire_data = '0;
        w_fire_data[0] = w_spike;
        w_fire_data[1 +: NIDX_W] = r_nidx;
        w_fire_data[11 +: TS_W] = r_ts;
        w_done_data = '0;
        w_done_data[TS_W-1:0] = r_ts;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ACCUM;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM: begin
                if (w_accept && w_op == OP_PSUM && w_last_part)
                    w_next = FIRE;
                else if (w_accept && w_op == OP_DONE)
                    w_next = SEND;
            end
            FIRE:    w_next = SEND;
            SEND:    if (i_out_ready) w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        o_in_ready  = (r_state == ACCUM) && r_rdy;
        o_out_valid = (r_state == SEND);
    end

    // Accumulation, integrate-and-fire and timestep bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdy        <= 1'b0;
            r_group_acc  <= '0;
            r_part_cnt   <= '0;
            r_nidx       <= '0;
            r_ts         <= '0;
            r_out_packet <= '0;
            r_err        <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++)
                r_vmem[i] <= '0;
        end else begin
            r_rdy <= 1'b1;
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_op == OP_PSUM) begin
                            r_group_acc <= r_group_acc + w_psum_ext;
                            r_part_cnt  <= r_part_cnt + PCNT_W'(1);
                        end else if (w_op == OP_DONE) begin
                            // An unfinished group at timestep end is dropped.
                            if (r_part_cnt != '0)
                                r_err <= 1'b1;
                            r_group_acc  <= '0;
                            r_part_cnt   <= '0;
                            r_nidx       <= '0;
                            r_out_packet <= {4'(OMEM_ID), OP_DONE, w_done_data};
                            if (r_ts == TS_W'(NUM_TIMESTEPS - 1)) begin
                                r_ts <= '0;
                                for (int i = 0; i < NUM_NEURONS; i++)
                                    r_vmem[i] <= '0;
                            end else begin
                                r_ts <= r_ts + TS_W'(1);
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    r_vmem[r_nidx] <= w_spike ? '0 : w_v;
                    r_out_packet   <= {4'(OMEM_ID), 4'(SPE_ID), w_fire_data};
                    r_group_acc    <= '0;
                    r_part_cnt     <= '0;
                    r_nidx         <= (r_nidx == NIDX_W'(NUM_NEURONS - 1)) ?
                                      '0 : r_nidx + NIDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_out_packet = r_out_packet;
    assign o_err        = r_err;

endmodule

// File: tb/tb_spe_accumulator.sv
// Bench for spe_accumulator: table of neuron groups with hand-computed spike
// packets, plus sequences for backpressure, timestep end and reset.
module tb_spe_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] in_packet = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [32:0] out_packet;
    logic        err;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    logic [32:0] q[$];
    logic [32:0] m_exp;

    spe_accumulator #(
        .SPE_ID(2), .OMEM_ID(11), .NUM_PARTIALS(5), .NUM_NEURONS(3),
        .NUM_TIMESTEPS(2), .PSUM_WIDTH(14), .VMEM_WIDTH(16), .THRESHOLD(64)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_packet(in_packet), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_packet(out_packet), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0][13:0] ps;
        logic [24:0]      exp;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input int a, b, c, d, e, input logic [24:0] x);
        vec_t v;
        v.ps[0] = 14'(a); v.ps[1] = 14'(b); v.ps[2] = 14'(c);
        v.ps[3] = 14'(d); v.ps[4] = 14'(e);
        v.exp = x;
        return v;
    endfunction

    // Outgoing packet: dest 11, given opcode field and payload.
    function automatic logic [32:0] pk(input logic [3:0] op, input logic [24:0] d);
        return {4'd11, op, d};
    endfunction

    // Incoming packet with a nonzero (ignored) address field.
    function automatic logic [32:0] pin(input logic [3:0] op, input logic [13:0] ps);
        return {4'h5, op, 11'h0, ps};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: acceptance happens at the posedge following this negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            delivered++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got %0h expected none", out_packet);
            end else begin
                m_exp = q.pop_front();
                if (out_packet !== m_exp) begin
                    errors++;
                    $display("FAIL out_pkt: got %0h expected %0h", out_packet, m_exp);
                end
            end
        end
    end

    task automatic send(input logic [32:0] p);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_packet = p;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_group(input vec_t v, input bit push);
        if (push) q.push_back(pk(4'd2, v.exp));
        for (int i = 0; i < 5; i++) send(pin(4'd0, v.ps[i]));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        int n = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_packet", 64'(out_packet), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        while (!in_ready && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("rst_in_ready_rises", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int d0;
        // Hand-computed spikes for NUM_NEURONS=3, THRESHOLD=64, ts=0.
        tbl[0]  = mk(20, 20, 20, 20, 20,          25'h001); // n0 100 spike
        tbl[1]  = mk(10, 10, 10, 10, 10,          25'h002); // n1 50
        tbl[2]  = mk(10, 10, 10, 10, 10,          25'h004); // n2 50
        tbl[3]  = mk(10, 10, 10, 10, 10,          25'h000); // n0 wrap, 50
        tbl[4]  = mk(10, 10, 10, 10, 10,          25'h003); // n1 100 spike
        tbl[5]  = mk(-8192, -8192, -8192, -8192, -8192, 25'h004); // n2 sat -32768
        tbl[6]  = mk(-8192, -8192, -8192, -8192, -8192, 25'h000); // n0 sat
        tbl[7]  = mk(-8192, -8192, -8192, -8192, -8192, 25'h002); // n1 sat
        tbl[8]  = mk(-8192, -8192, -8192, -8192, -8192, 25'h004); // n2 stays -32768
        tbl[9]  = mk(8191, 8191, 8191, 8191, 8191, 25'h001);      // n0 8187 spike
        tbl[10] = mk(100, -36, 0, 0, 0,           25'h002); // n1 -32704
        tbl[11] = mk(8191, 8191, 8191, 8191, 8191, 25'h005);      // n2 spike
        tbl[12] = mk(30, 34, 0, 0, 0,             25'h001); // n0 exactly 64
        tbl[13] = mk(63, 0, 0, 0, 0,              25'h002); // n1 -32641
        tbl[14] = mk(63, 0, 0, 0, 0,              25'h004); // n2 63, below
        tbl[15] = mk(8191, 8191, 8191, 8191, 8191, 25'h001);      // n0 sat +32767

        do_reset();

        for (int i = 0; i < 16; i++) send_group(tbl[i], 1'b1);
        wait_drain("table_drain");
        chk("table_count", 64'(delivered), 64'd16);

        // Backpressure on n1 (-32641 + 0): packet held, input ignored.
        @(posedge clk);
        #2 out_ready = 1'b0;
        send_group(mk(0, 0, 0, 0, 0, 25'h002), 1'b1);
        @(negedge clk);
        chk("fire_cycle_valid", 64'(out_valid), 64'd0);
        chk("fire_cycle_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("send_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_packet = pin(4'd0, 14'd1000);
        d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_pkt", 64'(out_packet), 64'(pk(4'd2, 25'h002)));
            chk("hold_ready_valid", 64'({in_ready, out_valid}), 64'b01);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain("hold_drain");
        repeat (3) @(negedge clk);
        chk("hold_once", 64'(delivered - d0), 64'd1);

        // Timestep end with 3 stray partials on n2.
        chk("err_before_done", 64'(err), 64'd0);
        for (int i = 0; i < 3; i++) send(pin(4'd0, 14'd1000));
        q.push_back(pk(4'd15, 25'd0));
        send(pin(4'd15, 14'd0));
        wait_drain("done0_drain");
        chk("done_err", 64'(err), 64'd1);
        // n0 (0) + 50, now at ts=1: nidx reset and partials dropped.
        send_group(mk(10, 10, 10, 10, 10, 25'h800), 1'b1);
        q.push_back(pk(4'd15, 25'd1));
        send(pin(4'd15, 14'd0));
        wait_drain("done1_drain");
        // ts wrapped and potentials cleared.
        send_group(mk(10, 10, 10, 10, 10, 25'h000), 1'b1);
        send_group(mk(13, 13, 13, 13, 13, 25'h003), 1'b1);
        wait_drain("wrap_drain");

        // Unknown opcode sets err, produces nothing.
        do_reset();
        d0 = delivered;
        send(pin(4'd3, 14'd55));
        repeat (4) @(negedge clk);
        chk("bad_op_err", 64'(err), 64'd1);
        chk("bad_op_no_out", 64'(delivered - d0), 64'd0);

        // Reset mid-group: next group starts clean at n0.
        do_reset();
        send(pin(4'd0, 14'd20));
        send(pin(4'd0, 14'd20));
        do_reset();
        send_group(mk(10, 10, 10, 10, 10, 25'h000), 1'b1);
        wait_drain("midgroup_drain");

        // Reset mid-SEND: packet abandoned, vmem cleared.
        @(posedge clk);
        #2 out_ready = 1'b0;
        send_group(mk(10, 10, 10, 10, 10, 25'h002), 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("midsend_valid", 64'(out_valid), 64'd1);
        end
        d0 = delivered;
        do_reset();
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("midsend_no_out", 64'(delivered - d0), 64'd0);
        send_group(mk(10, 10, 10, 10, 10, 25'h000), 1'b1);
        wait_drain("midsend_drain");
        chk("final_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
